// File: rtl/m68k_bus_ctrl_pkg.sv
// Shared types and helpers for the 68000 bus cycle controller:
// state/kind encodings, the IACK function code and saturating counter steps.
package m68k_bus_ctrl_pkg;

    localparam int ADDR_W = 24;
    localparam int WAIT_W = 4;
    localparam int TO_W   = 8;

    localparam logic [2:0] FC_IACK = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_ACK  = 3'd2,
        ST_BERR = 3'd3,
        ST_IACK = 3'd4
    } state_t;

    // What the decoded cycle turned out to be; resolved one clk after decode.
    typedef enum logic [1:0] {
        KIND_MEM      = 2'd0,
        KIND_IACK     = 2'd1,
        KIND_UNMAPPED = 2'd2
    } kind_t;

    function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [WAIT_W-1:0] sat_dec(input logic [WAIT_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

endpackage

// File: rtl/m68k_region_decode.sv
// Combinational base/mask region decoder; the lowest matching region index wins.
module m68k_region_decode
    import m68k_bus_ctrl_pkg::*;
#(
    parameter int                            C_REGIONS = 4,
    parameter logic [C_REGIONS*ADDR_W-1:0]   C_BASE    = '0,
    parameter logic [C_REGIONS*ADDR_W-1:0]   C_MASK    = '0
) (
    input  logic [22:0]          addr,
    output logic                 hit,
    output logic [2:0]           idx,
    output logic [C_REGIONS-1:0] onehot
);

    logic [ADDR_W-1:0] baddr;
    assign baddr = {addr, 1'b0};

    // Scan from the top down so a lower index overwrites any higher match.
    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int i = C_REGIONS - 1; i >= 0; i--) begin
            if ((baddr & C_MASK[i*ADDR_W +: ADDR_W]) ==
                (C_BASE[i*ADDR_W +: ADDR_W] & C_MASK[i*ADDR_W +: ADDR_W])) begin
                hit       = 1'b1;
                idx       = 3'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/m68k_bus_ctrl.sv
// 68000 bus cycle controller: region decode, wait states, slave ready,
// autovectored IACK and bus-error timeout in front of the fx68k core.
module m68k_bus_ctrl
    import m68k_bus_ctrl_pkg::*;
#(
    parameter int                                C_REGIONS       = 4,
    parameter logic [C_REGIONS*ADDR_W-1:0]       C_BASE          = {24'h060000, 24'h040000, 24'h020000, 24'h000000},
    parameter logic [C_REGIONS*ADDR_W-1:0]       C_MASK          = {4{24'hFE0000}},
    parameter logic [C_REGIONS*WAIT_W-1:0]       C_WAIT          = '0,
    parameter logic [C_REGIONS-1:0]              C_READY_EN      = '0,
    parameter int                                C_TIMEOUT       = 255,
    parameter bit                                C_UNMAPPED_BERR = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    as_n,
    input  logic                    rw,
    input  logic                    uds_n,
    input  logic                    lds_n,
    input  logic [22:0]             addr,
    input  logic [2:0]              fc,
    input  logic [C_REGIONS-1:0]    ready,
    input  logic [16*C_REGIONS-1:0] rdata_i,
    output logic                    dtack_n,
    output logic                    berr_n,
    output logic                    vpa_n,
    output logic [C_REGIONS-1:0]    cs,
    output logic                    we,
    output logic [1:0]              be,
    output logic [15:0]             rdata_o,
    output logic                    busy
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(C_TIMEOUT);

    logic                 dec_hit;
    logic [2:0]           dec_idx;
    logic [C_REGIONS-1:0] dec_onehot;

    m68k_region_decode #(
        .C_REGIONS (C_REGIONS),
        .C_BASE    (C_BASE),
        .C_MASK    (C_MASK)
    ) u_decode (
        .addr   (addr),
        .hit    (dec_hit),
        .idx    (dec_idx),
        .onehot (dec_onehot)
    );

    state_t               state_q, state_d;
    kind_t                kind_q, kind_d;
    logic [2:0]           idx_q, idx_d;
    logic                 rw_q, rw_d;
    logic                 armed_q, armed_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [C_REGIONS-1:0] cs_q, cs_d;
    logic [1:0]           be_q, be_d;
    logic                 we_q, we_d;
    logic [15:0]          rdata_q, rdata_d;
    logic                 busy_q, busy_d;
    logic                 dtack_n_q, dtack_n_d;
    logic                 berr_n_q, berr_n_d;
    logic                 vpa_n_q, vpa_n_d;

    logic [WAIT_W-1:0]    wait_ld;
    logic                 rdy_ok;
    logic [15:0]          rdata_sel;

    // Per-region parameter and data selection: wait load uses the live decode,
    // ready and read data use the region latched at decode.
    always_comb begin
        wait_ld   = '0;
        rdy_ok    = 1'b1;
        rdata_sel = '0;
        for (int i = 0; i < C_REGIONS; i++) begin
            if (dec_idx == 3'(i)) begin
                wait_ld = C_WAIT[i*WAIT_W +: WAIT_W];
            end
            if (idx_q == 3'(i)) begin
                rdy_ok    = !C_READY_EN[i] || ready[i];
                rdata_sel = rdata_i[i*16 +: 16];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        idx_d      = idx_q;
        rw_d       = rw_q;
        armed_d    = armed_q;
        wait_cnt_d = wait_cnt_q;
        to_cnt_d   = to_cnt_q;
        cs_d       = cs_q;
        be_d       = be_q;
        we_d       = 1'b0;
        rdata_d    = rdata_q;
        busy_d     = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (as_n) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d  = 1'b0;
                    busy_d   = 1'b1;
                    be_d     = {~uds_n, ~lds_n};
                    rw_d     = rw;
                    idx_d    = dec_idx;
                    to_cnt_d = '0;
                    state_d  = ST_WAIT;
                    if (fc == FC_IACK) begin
                        kind_d     = KIND_IACK;
                        cs_d       = '0;
                        wait_cnt_d = '0;
                    end else if (!dec_hit) begin
                        kind_d     = KIND_UNMAPPED;
                        cs_d       = '0;
                        wait_cnt_d = '0;
                    end else begin
                        kind_d     = KIND_MEM;
                        cs_d       = dec_onehot;
                        wait_cnt_d = wait_ld;
                    end
                end
            end
            ST_WAIT: begin
                // CPU withdrew the strobe: abandon the cycle without side effects.
                if (as_n) begin
                    state_d = ST_IDLE;
                    cs_d    = '0;
                    busy_d  = 1'b0;
                end else begin
                    unique case (kind_q)
                        KIND_IACK: state_d = ST_IACK;
                        KIND_UNMAPPED: begin
                            if (C_UNMAPPED_BERR) begin
                                state_d = ST_BERR;
                            end else begin
                                state_d = ST_ACK;
                                rdata_d = 16'hFFFF;
                            end
                        end
                        default: begin
                            // Timeout is checked first so it wins a tie with the wait count.
                            if (to_cnt_q == TO_LIMIT) begin
                                state_d = ST_BERR;
                                cs_d    = '0;
                            end else if (wait_cnt_q == '0 && rdy_ok) begin
                                state_d = ST_ACK;
                                rdata_d = rdata_sel;
                                we_d    = ~rw_q;
                            end else begin
                                wait_cnt_d = sat_dec(wait_cnt_q);
                                to_cnt_d   = sat_inc(to_cnt_q);
                            end
                        end
                    endcase
                end
            end
            ST_ACK, ST_BERR, ST_IACK: begin
                if (as_n) begin
                    state_d = ST_IDLE;
                    cs_d    = '0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        dtack_n_d = (state_d != ST_ACK);
        berr_n_d  = (state_d != ST_BERR);
        vpa_n_d   = (state_d != ST_IACK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            kind_q     <= KIND_MEM;
            idx_q      <= '0;
            rw_q       <= 1'b1;
            armed_q    <= 1'b0;
            wait_cnt_q <= '0;
            to_cnt_q   <= '0;
            cs_q       <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            dtack_n_q  <= 1'b1;
            berr_n_q   <= 1'b1;
            vpa_n_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            idx_q      <= idx_d;
            rw_q       <= rw_d;
            armed_q    <= armed_d;
            wait_cnt_q <= wait_cnt_d;
            to_cnt_q   <= to_cnt_d;
            cs_q       <= cs_d;
            be_q       <= be_d;
            we_q       <= we_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            dtack_n_q  <= dtack_n_d;
            berr_n_q   <= berr_n_d;
            vpa_n_q    <= vpa_n_d;
        end
    end

    assign dtack_n = dtack_n_q;
    assign berr_n  = berr_n_q;
    assign vpa_n   = vpa_n_q;
    assign cs      = cs_q;
    assign we      = we_q;
    assign be      = be_q;
    assign rdata_o = rdata_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Scoreboard bench for m68k_bus_ctrl: one instance maps unmapped accesses to
// BERRn, a second one to DTACKn with 16'hFFFF.
module tb_m68k_bus_ctrl;

    localparam int N = 4;
    localparam logic [N*24-1:0] BASE  = {24'h060000, 24'h040000, 24'h020000, 24'h000000};
    localparam logic [N*24-1:0] MASK  = {4{24'hFE0000}};
    localparam logic [N*4-1:0]  WAITS = {4'h3, 4'h1, 4'h0, 4'h0};
    localparam logic [N-1:0]    RDYEN = 4'b0010;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          as_n = 1'b1;
    logic          rw = 1'b1;
    logic          uds_n = 1'b1;
    logic          lds_n = 1'b1;
    logic [22:0]   addr = '0;
    logic [2:0]    fc = 3'b101;
    logic [N-1:0]  ready = '0;
    logic [16*N-1:0] rdata_i = {16'hC0DE, 16'h5A5A, 16'hBEEF, 16'h1234};

    logic          dtack_n, berr_n, vpa_n, we, busy;
    logic [N-1:0]  cs;
    logic [1:0]    be;
    logic [15:0]   rdata_o;
    logic          dtack_n0, berr_n0, vpa_n0, we0, busy0;
    logic [N-1:0]  cs0;
    logic [1:0]    be0;
    logic [15:0]   rdata_o0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          strobe;   // 0 dtack, 1 berr, 2 vpa
        int          lat;      // posedges from E0 (inclusive) until strobe seen
        logic [15:0] rdata;
        bit          chk_rdata;
        int          we_cnt;
        logic [N-1:0] cs;
        logic [1:0]  be;
    } exp_t;

    exp_t sb_q[$];

    m68k_bus_ctrl #(
        .C_REGIONS(N), .C_BASE(BASE), .C_MASK(MASK), .C_WAIT(WAITS),
        .C_READY_EN(RDYEN), .C_TIMEOUT(255), .C_UNMAPPED_BERR(1'b1)
    ) u_dut (
        .clk(clk), .reset(reset), .as_n(as_n), .rw(rw), .uds_n(uds_n), .lds_n(lds_n),
        .addr(addr), .fc(fc), .ready(ready), .rdata_i(rdata_i),
        .dtack_n(dtack_n), .berr_n(berr_n), .vpa_n(vpa_n), .cs(cs), .we(we),
        .be(be), .rdata_o(rdata_o), .busy(busy)
    );

    m68k_bus_ctrl #(
        .C_REGIONS(N), .C_BASE(BASE), .C_MASK(MASK), .C_WAIT(WAITS),
        .C_READY_EN(RDYEN), .C_TIMEOUT(255), .C_UNMAPPED_BERR(1'b0)
    ) u_dut0 (
        .clk(clk), .reset(reset), .as_n(as_n), .rw(rw), .uds_n(uds_n), .lds_n(lds_n),
        .addr(addr), .fc(fc), .ready(ready), .rdata_i(rdata_i),
        .dtack_n(dtack_n0), .berr_n(berr_n0), .vpa_n(vpa_n0), .cs(cs0), .we(we0),
        .be(be0), .rdata_o(rdata_o0), .busy(busy0)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(int s, int l, logic [15:0] rd, bit crd, int w, logic [N-1:0] c, logic [1:0] b);
        exp_t e;
        e.strobe = s; e.lat = l; e.rdata = rd; e.chk_rdata = crd;
        e.we_cnt = w; e.cs = c; e.be = b;
        return e;
    endfunction

    // One full bus cycle; rdy_at = iteration at which ready[1] is raised (-1: never).
    task automatic run_cycle(input string nm, input logic [23:0] baddr, input logic [2:0] f,
                             input logic r, input logic u, input logic l, input bit alt,
                             input int rdy_at, input exp_t e);
        exp_t x;
        int n, we_cnt, strobe, nlow;
        bit seen;
        logic dt, bn, vp, ws, bs;
        logic [N-1:0] cs_s;
        logic [1:0] be_s;
        logic [15:0] rd_s;
        as_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        addr = baddr[23:1]; fc = f; rw = r; uds_n = u; lds_n = l;
        sb_q.push_back(e);
        as_n = 1'b0;
        n = 0; we_cnt = 0; seen = 1'b0;
        dt = 1'b1; bn = 1'b1; vp = 1'b1; cs_s = '0; be_s = '0; rd_s = '0;
        while (!seen && n < 400) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            dt   = alt ? dtack_n0 : dtack_n;
            bn   = alt ? berr_n0  : berr_n;
            vp   = alt ? vpa_n0   : vpa_n;
            ws   = alt ? we0      : we;
            bs   = alt ? busy0    : busy;
            cs_s = alt ? cs0      : cs;
            be_s = alt ? be0      : be;
            rd_s = alt ? rdata_o0 : rdata_o;
            if (ws) we_cnt++;
            nlow = int'(!dt) + int'(!bn) + int'(!vp);
            if (nlow > 1) check_eq({nm, "_excl"}, nlow, 1);
            if (n == 1) check_eq({nm, "_busy"}, bs, 1'b1);
            if (n == rdy_at) ready[1] = 1'b1;
            if (!dt || !bn || !vp) seen = 1'b1;
        end
        x = sb_q.pop_front();
        if (!seen) begin
            check_eq({nm, "_no_strobe"}, n, x.lat);
        end else begin
            strobe = !dt ? 0 : (!bn ? 1 : 2);
            check_eq({nm, "_strobe"}, strobe, x.strobe);
            check_eq({nm, "_lat"}, n, x.lat);
            check_eq({nm, "_cs"}, cs_s, x.cs);
            check_eq({nm, "_be"}, be_s, x.be);
            if (x.chk_rdata) check_eq({nm, "_rdata"}, rd_s, x.rdata);
        end
        as_n = 1'b1;
        ready = '0;
        @(posedge clk);
        @(negedge clk);
        if (alt ? we0 : we) we_cnt++;
        check_eq({nm, "_release"},
                 {alt ? dtack_n0 : dtack_n, alt ? berr_n0 : berr_n, alt ? vpa_n0 : vpa_n,
                  alt ? busy0 : busy, 4'(alt ? cs0 : cs)}, {3'b111, 1'b0, 4'b0000});
        @(posedge clk);
        @(negedge clk);
        if (alt ? we0 : we) we_cnt++;
        check_eq({nm, "_we_cnt"}, we_cnt, x.we_cnt);
    endtask

    task automatic check_reset_vals(input string nm);
        check_eq({nm, "_strobes"}, {dtack_n, berr_n, vpa_n, dtack_n0, berr_n0, vpa_n0}, 6'b111111);
        check_eq({nm, "_cs_we_busy"}, {cs, we, busy}, '0);
        check_eq({nm, "_be"}, be, 2'b00);
        check_eq({nm, "_rdata"}, rdata_o, 16'h0000);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst0");
        reset = 1'b0;

        run_cycle("rd_r0", 24'h000100, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, -1,
                  mk(0, 2, 16'h1234, 1'b1, 0, 4'b0001, 2'b11));
        run_cycle("wr_r3", 24'h060010, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, -1,
                  mk(0, 5, 16'hC0DE, 1'b0, 1, 4'b1000, 2'b10));
        run_cycle("rd_r2", 24'h040022, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0, -1,
                  mk(0, 3, 16'h5A5A, 1'b1, 0, 4'b0100, 2'b01));
        run_cycle("rdy_r1", 24'h020040, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 20,
                  mk(0, 21, 16'hBEEF, 1'b1, 0, 4'b0010, 2'b11));
        run_cycle("tmo_r1", 24'h020040, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, -1,
                  mk(1, 257, 16'h0, 1'b0, 0, 4'b0000, 2'b11));
        run_cycle("iack", 24'h0F0000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, -1,
                  mk(2, 2, 16'h0, 1'b0, 0, 4'b0000, 2'b11));
        run_cycle("unmap_berr", 24'hFF0000, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, -1,
                  mk(1, 2, 16'h0, 1'b0, 0, 4'b0000, 2'b11));
        run_cycle("unmap_ack", 24'hFF0000, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1, -1,
                  mk(0, 2, 16'hFFFF, 1'b1, 0, 4'b0000, 2'b11));
        run_cycle("rd_r0b", 24'h000200, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, -1,
                  mk(0, 2, 16'h1234, 1'b1, 0, 4'b0001, 2'b11));

        // Abort: as_n withdrawn while region 3 is still counting wait states.
        as_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        addr = 23'(24'h060000 >> 1); rw = 1'b0; fc = 3'b101; as_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        as_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!dtack_n || we) check_eq("abort_no_ack", {dtack_n, we}, 2'b10);
        end
        check_eq("abort_rdata", rdata_o, 16'h1234);
        check_eq("abort_idle", {busy, cs}, '0);

        // Reset in the middle of a wait with the strobe still low.
        @(negedge clk);
        addr = 23'(24'h060000 >> 1); rw = 1'b1; as_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq("pre_rst_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check_reset_vals("rst_wait");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!dtack_n || busy) check_eq("rst_no_decode", {dtack_n, busy}, 2'b10);
        end
        check_eq("rst_hold_busy", busy, 1'b0);
        run_cycle("post_rst", 24'h000300, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, -1,
                  mk(0, 2, 16'h1234, 1'b1, 0, 4'b0001, 2'b11));

        check_eq("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
